// File: rtl/ppa_pkg.sv
// ppa_pkg
// Shared constants and helpers for the partial-product accumulator and the
// thermometer-to-binary encoder that feeds it.
//   IN_WIDTH_DEF / NUM_TERMS_DEF : default term width and frame length
//   MINUS_32                     : most negative encoder term
//   sext_term()                  : sign-extends an IN_WIDTH term (carried in a
//                                  32-bit container) to a 32-bit signed value
//   frame_cnt_w()                : width of the term counter for a frame length
package ppa_pkg;

    localparam int IN_WIDTH_DEF  = 7;
    localparam int NUM_TERMS_DEF = 8;

    localparam logic signed [IN_WIDTH_DEF-1:0] MINUS_32 = -7'sd32;

    // Shift the term's sign bit up to bit 31, then arithmetic-shift it back.
    function automatic logic signed [31:0] sext_term(input logic [31:0] raw,
                                                     input int          width);
        logic signed [31:0] t;
        t = signed'(raw << (32 - width));
        return t >>> (32 - width);
    endfunction

    // Counter must hold 0..n-1; a 1-bit counter is the floor.
    function automatic int frame_cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/partial_product_accumulator.sv
// partial_product_accumulator
// Sums fixed-length frames of signed terms from the priority encoder and
// hands each frame sum to a consumer through a 1-entry registered output.
// The next frame accumulates while the previous sum waits to be taken.
//
// Optional feature macro: PPA_EARLY_LAST_EN adds in_last, which ends a frame
// on the accepted term that carries it.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   clear      : synchronous flush of frame in progress and held result
//   in_valid   : in_data is valid
//   in_ready   : term accepted this cycle when in_valid is also high
//   in_data    : signed IN_WIDTH term
//   in_last    : (PPA_EARLY_LAST_EN only) accepted term ends the frame
//   out_valid  : out_sum holds a completed frame sum
//   out_ready  : consumer takes out_sum this cycle
//   out_sum    : signed OUT_WIDTH frame sum
//   out_frames : completed-frame count, wraps modulo 2^16
module partial_product_accumulator
    import ppa_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int NUM_TERMS = NUM_TERMS_DEF,
    parameter int OUT_WIDTH = IN_WIDTH + $clog2(NUM_TERMS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
`ifdef PPA_EARLY_LAST_EN
    input  logic                 in_last,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_sum,
    output logic [15:0]          out_frames
);

    localparam int              CNT_W    = frame_cnt_w(NUM_TERMS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TERMS - 1);

    logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0] out_sum_q, out_sum_d;
    logic        [CNT_W-1:0]     cnt_q, cnt_d;
    logic                        out_valid_q, out_valid_d;
    logic        [15:0]          frames_q, frames_d;

    logic signed [OUT_WIDTH-1:0] term_ext;
    logic signed [OUT_WIDTH-1:0] sum_next;
    logic                        last_term;
    logic                        accept;
    logic                        final_accept;

    assign term_ext = OUT_WIDTH'(sext_term(32'(in_data), IN_WIDTH));
    assign sum_next = acc_q + term_ext;

`ifdef PPA_EARLY_LAST_EN
    assign last_term = (cnt_q == LAST_IDX) || in_last;
`else
    assign last_term = (cnt_q == LAST_IDX);
`endif

    // Stall only when a final term would overwrite a sum nobody has taken;
    // a sum leaving this very cycle frees the register for the new one.
    assign in_ready     = !(last_term && out_valid_q && !out_ready) && !clear;
    assign accept       = in_valid && in_ready;
    assign final_accept = accept && last_term;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
        frames_d    = frames_q;
        if (clear) begin
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            // A final accept in the same cycle as a take reloads the
            // register, keeping out_valid high for back-to-back frames.
            if (final_accept) begin
                out_sum_d   = sum_next;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                frames_d    = frames_q + 16'd1;
            end else if (accept) begin
                acc_d = sum_next;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            frames_q    <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
            frames_q    <= frames_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sum    = out_sum_q;
    assign out_frames = frames_q;

endmodule

// File: doc/partial_product_accumulator.md
Name: partial_product_accumulator

Overview:
- Downstream stage of the thermometer-to-binary priority encoder.
- Consumes its 7-bit two's-complement terms (range -32..+31) through a valid/ready handshake.
- Sums a fixed-length frame of NUM_TERMS terms and presents each frame sum on a registered output with its own valid/ready handshake.
- The accumulator keeps running on the next frame while the previous sum waits for the consumer.

Parameters:
- IN_WIDTH, 7: signed width of each input term.
- NUM_TERMS, 8: terms per frame; legal values are 2 or more.
- OUT_WIDTH, IN_WIDTH+$clog2(NUM_TERMS): signed sum width; it is sized so the sum never overflows.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- clear  in  1  synchronous flush of the frame in progress and of any held result.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  IN_WIDTH  signed term from the encoder.
- out_valid  out  1  out_sum holds a completed frame sum.
- out_ready  in  1  consumer takes out_sum this cycle.
- out_sum  out  OUT_WIDTH  signed frame sum.
- out_frames  out  16  count of completed frames; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, active-high):
  - acc=0, term_cnt=0, out_valid=0, out_sum=0, out_frames=0.
  - in_ready reads 1 once rst is released.
- Accept rule: a term is accepted when in_valid && in_ready. Each accepted term is sign-extended to OUT_WIDTH before it is added.
- in_ready is combinational: in_ready = !(term_cnt==NUM_TERMS-1 && out_valid && !out_ready) && !clear.
  - It only deasserts when the last term of a frame would overwrite a result that has not been taken.
- Non-final accept (term_cnt<NUM_TERMS-1): acc <= acc+ext(in_data); term_cnt <= term_cnt+1.
- Final accept (term_cnt==NUM_TERMS-1):
  - out_sum <= acc+ext(in_data); out_valid <= 1.
  - acc <= 0; term_cnt <= 0; out_frames <= out_frames+1.
- Latency: out_valid rises the cycle after the final term is accepted.
- Output handshake:
  - out_valid falls after out_valid && out_ready, unless a new final accept happens in the same cycle.
  - In that same-cycle case out_valid stays 1 and out_sum loads the new sum, so back-to-back frames run at full rate.
- While out_valid=1 and out_ready=0, out_sum is held stable.
- Frame-state machine: ACCUM (term_cnt 0..NUM_TERMS-1) and HOLD (out_valid=1). These states are orthogonal, not exclusive.
- clear=1:
  - acc=0, term_cnt=0, out_valid=0; in_ready=0; any in_valid that cycle is dropped.
  - out_frames is not cleared.
  - clear has priority over any simultaneous accept or output handshake.
- Reset mid-frame drops the partial sum and any held result immediately (asynchronously).
- out_frames wraps from 0xFFFF to 0.

Optional Feature:
- Macro PPA_EARLY_LAST_EN.
- Defined:
  - Adds input port in_last (1 bit), qualified by the accept.
  - An accepted term with in_last=1 ends the frame early: it is treated as a final accept whatever term_cnt is.
  - The in_ready stall condition becomes (term_cnt==NUM_TERMS-1 || in_last).
  - A frame with in_last=1 on its first term yields the sum of that one term.
- Not defined: the in_last port does not exist; frames are exactly NUM_TERMS terms.

Decomposition:
- Package ppa_pkg:
  - Default IN_WIDTH/NUM_TERMS constants.
  - MINUS_32 constant shared with the encoder.
  - A function sext_term() that sign-extends IN_WIDTH to OUT_WIDTH.
  - The frame-counter width function.
- No sub-module is required. The output register and handshake may optionally be split out as ppa_out_reg (1-entry valid/ready holding register) if the output side is reused elsewhere.

Test Plan:
- NUM_TERMS=4: four terms of -32, out_ready=1 → out_valid one cycle after the 4th accept, out_sum=-128 (9'h180), out_frames=1.
- NUM_TERMS=4: terms 31,31,31,31 followed at once by -1,0,5,-4 with no gap, out_ready=1 → sums 124 then 0 on consecutive frames; in_ready never drops.
- Backpressure: hold out_ready=0 after frame 1 (sum 10) and send 4 more terms → in_ready=0 on the 4th term until out_ready=1. Then out_sum=10 is taken and the new sum loads in the cycle after the final accept; out_sum is stable throughout the stall.
- Assert clear after 2 of 4 terms (7,7), then send 1,1,1,1 → out_sum=4, not 18; out_frames unchanged by the clear.
- Assert rst asynchronously mid-frame and mid-HOLD → all outputs 0 within the same cycle; the next full frame of 2,2,2,2 → 8.
- With PPA_EARLY_LAST_EN: terms 3,-5 with in_last on -5 → out_sum=-2 after 2 terms; the next frame of 4 terms counts from 0.
